fib_seq_display: RTL and testbench

- Parametrised Fibonacci sequence generator that drives a DIGITS-wide bank of 7-segment displays.
- Successor to the fixed 8-bit, 3-digit generator. Adds configurable width and digit count, a configurable tick rate, and run/step/restart control.
- Decodes by sequential binary-to-BCD conversion instead of a value lookup table, so every value is shown, not only listed ones.
- Adds a sticky overflow flag and a dash pattern for values that do not fit the display.
- Sits between the board clock/keys and the HEX display pins.

---
 rtl/fib_disp_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/fib_seq_display.sv | 115 +++++++++++
 tb/tb_fib_seq_display.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_disp_pkg.sv
// Shared definitions for the Fibonacci 7-segment display: segment codes,
// converter state encoding and BCD sizing helper.
package fib_disp_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd, input logic active_low);
        logic [6:0] p;
        case (bcd)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_DASH;
        endcase
        return active_low ? p : ~p;
    endfunction

    // ceil(width*0.302)+1 in integer arithmetic
    function automatic int bcd_digits(input int width);
        return (width * 302 + 999) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock,
// result valid while done is high.
module bin2bcd_seq
    import fib_disp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);
    localparam int SW = 4 * NDIG + WIDTH;
    localparam int IW = $clog2(WIDTH + 1);

    conv_state_e     state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [IW-1:0]   it_q, it_d;

    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int k = 0; k < NDIG; k++) begin
            if (t[WIDTH + 4*k +: 4] >= 4'd5)
                t[WIDTH + 4*k +: 4] = t[WIDTH + 4*k +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        it_d    = it_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD: begin
                sr_d    = SW'(bin);
                it_d    = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d = dabble(sr_q);
                it_d = it_q + 1'b1;
                if (it_q == IW'(WIDTH - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            it_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            it_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            it_q    <= it_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = sr_q[SW-1 -: 4*NDIG];

endmodule

// File: rtl/fib_seq_display.sv
// Fibonacci sequence generator with run/step/restart control, driving a bank
// of 7-segment digits through a sequential BCD converter.
module fib_seq_display
    import fib_disp_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int TICK_DIV       = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  restart,
    output logic [7*DIGITS-1:0]   hex,
    output logic [WIDTH-1:0]      value,
    output logic                  overflow,
    output logic                  busy
);
    localparam int         NB       = bcd_digits(WIDTH);
    localparam int         EXT      = (NB > DIGITS) ? NB : DIGITS;
    localparam int         CW       = $clog2(TICK_DIV);
    localparam logic       AL       = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] ZERO_PAT = seg_encode(4'd0, AL);
    localparam logic [6:0] DASH_PAT = AL ? SEG_DASH : ~SEG_DASH;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     prev_q, prev_d, cur_q, cur_d;
    logic                 ovf_q, ovf_d, start_q, start_d;
    logic [7*DIGITS-1:0]  hex_q, hex_d, seg_pat;
    logic                 tick, adv, conv_busy, conv_done, dash;
    logic [WIDTH:0]       sum;
    logic [4*NB-1:0]      bcd;
    logic [4*EXT-1:0]     bcd_ext;

    assign tick = run && (cnt_q == CW'(TICK_DIV - 1));
    assign sum  = {1'b0, prev_q} + {1'b0, cur_q};
    // start_q covers the cycle between an advance and the converter leaving IDLE
    assign adv  = ((run & tick) | (~run & step)) & ~conv_busy & ~start_q;

    always_comb begin
        bcd_ext = '0;
        bcd_ext[4*NB-1:0] = bcd;
        dash = 1'b0;
        for (int k = DIGITS; k < EXT; k++)
            dash = dash | (bcd_ext[4*k +: 4] != 4'd0);
        seg_pat = '0;
        for (int k = 0; k < DIGITS; k++)
            seg_pat[7*k +: 7] = dash ? DASH_PAT : seg_encode(bcd_ext[4*k +: 4], AL);
    end

    always_comb begin
        cnt_d   = (!run || tick) ? '0 : cnt_q + 1'b1;
        prev_d  = prev_q;
        cur_d   = cur_q;
        ovf_d   = ovf_q;
        start_d = adv;
        hex_d   = hex_q;
        if (adv) begin
            if (sum[WIDTH]) begin
                ovf_d  = 1'b1;
                prev_d = '0;
                cur_d  = WIDTH'(1);
            end else begin
                prev_d = cur_q;
                cur_d  = sum[WIDTH-1:0];
            end
        end
        if (conv_done) hex_d = seg_pat;
        if (restart) begin
            cnt_d   = '0;
            prev_d  = '0;
            cur_d   = WIDTH'(1);
            ovf_d   = 1'b0;
            start_d = 1'b0;
            hex_d   = {DIGITS{ZERO_PAT}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            prev_q  <= '0;
            cur_q   <= WIDTH'(1);
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            hex_q   <= {DIGITS{ZERO_PAT}};
        end else begin
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            hex_q   <= hex_d;
        end
    end

    bin2bcd_seq #(.WIDTH(WIDTH), .NDIG(NB)) u_conv (
        .clk   (clk),
        .reset (reset),
        .clear (restart),
        .start (start_q),
        .bin   (prev_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign hex      = hex_q;
    assign value    = prev_q;
    assign overflow = ovf_q;
    assign busy     = conv_busy;

endmodule

// File: tb/tb_fib_seq_display.sv
// Scoreboard bench for fib_seq_display: three configurations share one
// stimulus stream; a decimal/Fibonacci reference model predicts each display.
module tb_fib_seq_display;

    localparam int TD = 24;

    typedef struct {
        int          vcyc;
        logic [69:0] val;
        logic        ovf;
        logic [69:0] hex;
    } exp_t;

    logic clk = 1'b0;
    logic reset, run, step, restart;
    logic [20:0] hex0;  logic [7:0]  val0;  logic ovf0, busy0;
    logic [13:0] hex1;  logic [7:0]  val1;  logic ovf1, busy1;
    logic [34:0] hex2;  logic [15:0] val2;  logic ovf2, busy2;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    logic pb0 = 1'b0, pb1 = 1'b0, pb2 = 1'b0;

    longint ma[3], mb[3];
    bit     mo[3];
    int     last[3];
    int     PW[3]  = '{8, 8, 16};
    int     PD[3]  = '{3, 2, 5};
    bit     PAL[3] = '{1'b1, 1'b1, 1'b0};

    fib_seq_display #(.WIDTH(8), .DIGITS(3), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .reset(reset), .run(run), .step(step), .restart(restart),
        .hex(hex0), .value(val0), .overflow(ovf0), .busy(busy0));
    fib_seq_display #(.WIDTH(8), .DIGITS(2), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1)) dut1 (
        .clk(clk), .reset(reset), .run(run), .step(step), .restart(restart),
        .hex(hex1), .value(val1), .overflow(ovf1), .busy(busy1));
    fib_seq_display #(.WIDTH(16), .DIGITS(5), .TICK_DIV(TD), .SEG_ACTIVE_LOW(0)) dut2 (
        .clk(clk), .reset(reset), .run(run), .step(step), .restart(restart),
        .hex(hex2), .value(val2), .overflow(ovf2), .busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [69:0] exp_hex(input longint v, input int d, input bit al);
        logic [69:0] h;
        logic [6:0]  c;
        longint      lim, t;
        h = '0;
        lim = 1;
        t = v;
        for (int k = 0; k < d; k++) lim = lim * 10;
        for (int k = 0; k < d; k++) begin
            c = (v >= lim) ? 7'b0111111 : seg_code(int'(t % 10));
            t = t / 10;
            h[7*k +: 7] = al ? c : ~c;
        end
        return h;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int vcyc);
        exp_t e;
        e.vcyc = vcyc;
        e.val  = 70'(ma[id]);
        e.ovf  = mo[id];
        e.hex  = exp_hex(ma[id], PD[id], PAL[id]);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // An advance is taken only once the previous display update has finished
    task automatic model_adv(input int id, input int edge_n);
        longint lim;
        lim = (longint'(1) << PW[id]) - 1;
        if (edge_n - last[id] >= PW[id] + 4) begin
            if (ma[id] + mb[id] > lim) begin
                mo[id] = 1'b1;
                ma[id] = 0;
                mb[id] = 1;
            end else begin
                longint s;
                s = ma[id] + mb[id];
                ma[id] = mb[id];
                mb[id] = s;
            end
            last[id] = edge_n;
            push(id, edge_n + PW[id] + 3);
        end
    endtask

    task automatic model_zero(input int vcyc);
        q0.delete(); q1.delete(); q2.delete();
        for (int id = 0; id < 3; id++) begin
            ma[id] = 0; mb[id] = 1; mo[id] = 1'b0; last[id] = -1000;
            push(id, vcyc);
        end
    endtask

    task automatic adv_all(input int edge_n);
        for (int id = 0; id < 3; id++) model_adv(id, edge_n);
    endtask

    task automatic chk_entry(input int id, input exp_t e, input logic [69:0] v,
                             input logic o, input logic [69:0] h);
        chk($sformatf("dut%0d_latency", id), 70'(cyc), 70'(e.vcyc));
        chk($sformatf("dut%0d_value", id), v, e.val);
        chk($sformatf("dut%0d_overflow", id), 70'(o), 70'(e.ovf));
        chk($sformatf("dut%0d_hex", id), h, e.hex);
    endtask

    task automatic chk_clear(input int id, input logic [69:0] v, input logic o,
                             input logic b, input logic [69:0] h);
        chk($sformatf("dut%0d_clr_value", id), v, 70'd0);
        chk($sformatf("dut%0d_clr_overflow", id), 70'(o), 70'd0);
        chk($sformatf("dut%0d_clr_busy", id), 70'(b), 70'd0);
        chk($sformatf("dut%0d_clr_hex", id), h, exp_hex(0, PD[id], PAL[id]));
    endtask

    task automatic chk_all_clear();
        chk_clear(0, 70'(val0), ovf0, busy0, 70'(hex0));
        chk_clear(1, 70'(val1), ovf1, busy1, 70'(hex1));
        chk_clear(2, 70'(val2), ovf2, busy2, 70'(hex2));
    endtask

    // Monitors: a falling busy marks a new display pattern
    always @(negedge clk) begin
        if (pb0 && !busy0) begin
            if (q0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut0_unexpected: got value %0d expected no update", val0);
            end else begin
                e0 = q0.pop_front();
                chk_entry(0, e0, 70'(val0), ovf0, 70'(hex0));
            end
        end
        pb0 = busy0;
    end

    always @(negedge clk) begin
        if (pb1 && !busy1) begin
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut1_unexpected: got value %0d expected no update", val1);
            end else begin
                e1 = q1.pop_front();
                chk_entry(1, e1, 70'(val1), ovf1, 70'(hex1));
            end
        end
        pb1 = busy1;
    end

    always @(negedge clk) begin
        if (pb2 && !busy2) begin
            if (q2.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut2_unexpected: got value %0d expected no update", val2);
            end else begin
                e2 = q2.pop_front();
                chk_entry(2, e2, 70'(val2), ovf2, 70'(hex2));
            end
        end
        pb2 = busy2;
    end

    task automatic run_ticks(input int k);
        run = 1'b1;
        for (int c = 1; c <= k * TD; c++) begin
            if (c % TD == 0) adv_all(cyc + 1);
            step = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        step = 1'b0;
        run  = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        adv_all(cyc + 1);
        @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; step = 1'b0; restart = 1'b0;
        for (int id = 0; id < 3; id++) begin
            ma[id] = 0; mb[id] = 1; mo[id] = 1'b0; last[id] = -1000;
        end
        repeat (2) @(negedge clk);
        chk_all_clear();
        reset = 1'b0;

        // Free-running past the overflow point of every configuration
        run_ticks(30);
        repeat (25) @(negedge clk);

        // Stepping: a back-to-back pair, then random spacing
        pulse_step();
        @(negedge clk);
        pulse_step();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            pulse_step();
        end
        repeat (40) @(negedge clk);

        // Synchronous restart in the middle of a conversion
        pulse_step();
        repeat (5) @(negedge clk);
        model_zero(cyc + 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_all_clear();

        run_ticks(20);
        repeat (40) @(negedge clk);

        // Asynchronous reset between edges during a conversion
        pulse_step();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        model_zero(cyc);
        reset = 1'b1;
        #1;
        chk_all_clear();
        @(negedge clk);
        reset = 1'b0;

        pulse_step();
        repeat (40) @(negedge clk);
        chk("dut0_pending", 70'(q0.size()), 70'd0);
        chk("dut1_pending", 70'(q1.size()), 70'd0);
        chk("dut2_pending", 70'(q2.size()), 70'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
